bp_cfg_loader: RTL

- Boot-time configuration sequencer for a multicore build: walks every core tile and writes its config registers over a shared valid/ready config link.
- Per core it writes freeze, core ID and mesh coordinates; after all cores are set up, it unfreezes every core.
- Sits between the top-level reset and the per-tile config endpoints. Core count and mesh shape come from the selected processor config.
- Raises `done_o` when the whole sequence has completed.

---
 rtl/bp_cfg_link_pkg.sv | 32 +++
 rtl/bp_cfg_loader_if.sv | 30 +++
 rtl/bp_cfg_cord_counter.sv | 48 ++++
 rtl/bp_cfg_loader.sv | 110 +++++++++++
 4 files changed

// File: rtl/bp_cfg_link_pkg.sv
// Shared types for the boot-time config link: register map, loader states,
// and the packed mesh-coordinate word.
package bp_cfg_link_pkg;

    localparam int cfg_reg_width_gp = 16;

    typedef enum logic [cfg_reg_width_gp-1:0] {
        e_cfg_freeze  = 16'h0002,
        e_cfg_core_id = 16'h0004,
        e_cfg_cord    = 16'h0008
    } bp_cfg_reg_e;

    typedef enum logic [2:0] {
        e_reset    = 3'd0,
        e_freeze   = 3'd1,
        e_core_id  = 3'd2,
        e_cord     = 3'd3,
        e_unfreeze = 3'd4,
        e_done     = 3'd5
    } bp_cfg_loader_state_e;

    typedef struct packed {
        logic [15:0] y;
        logic [15:0] x;
    } bp_cfg_cord_s;

    // Counter width that never collapses to zero bits for a dimension of 1.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bp_cfg_loader_if.sv
// Valid/ready config write link from the loader to the per-tile endpoints.
interface bp_cfg_loader_if #(
    parameter int core_width_p = 1,
    parameter int addr_width_p = 16,
    parameter int data_width_p = 32
);

    logic                    cfg_v_o;
    logic                    cfg_ready_i;
    logic [core_width_p-1:0] cfg_core_o;
    logic [addr_width_p-1:0] cfg_addr_o;
    logic [data_width_p-1:0] cfg_data_o;

    modport master (
        output cfg_v_o,
        output cfg_core_o,
        output cfg_addr_o,
        output cfg_data_o,
        input  cfg_ready_i
    );

    modport slave (
        input  cfg_v_o,
        input  cfg_core_o,
        input  cfg_addr_o,
        input  cfg_data_o,
        output cfg_ready_i
    );

endinterface

// File: rtl/bp_cfg_cord_counter.sv
// Walks core index and its (x, y) mesh position in lockstep; x wraps at the
// mesh width and carries into y, so no divider is needed.
module bp_cfg_cord_counter
    import bp_cfg_link_pkg::*;
#(
    parameter  int num_core_p    = 1,
    parameter  int cc_x_dim_p    = 1,
    localparam int core_width_lp = safe_clog2(num_core_p),
    localparam int x_width_lp    = safe_clog2(cc_x_dim_p),
    localparam int y_width_lp    = safe_clog2(num_core_p / cc_x_dim_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     clear_i,
    input  logic                     incr_i,
    output logic [core_width_lp-1:0] core_o,
    output logic [x_width_lp-1:0]    x_o,
    output logic [y_width_lp-1:0]    y_o,
    output logic                     last_o
);

    localparam logic [core_width_lp-1:0] last_core_lp =
        core_width_lp'(num_core_p - 1);
    localparam logic [x_width_lp-1:0] last_x_lp =
        x_width_lp'(cc_x_dim_p - 1);

    logic x_wrap;

    assign x_wrap = (x_o == last_x_lp);
    assign last_o = (core_o == last_core_lp);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            core_o <= '0;
            x_o    <= '0;
            y_o    <= '0;
        end else if (clear_i) begin
            core_o <= '0;
            x_o    <= '0;
            y_o    <= '0;
        end else if (incr_i) begin
            core_o <= core_o + 1'b1;
            x_o    <= x_wrap ? '0 : x_o + 1'b1;
            y_o    <= x_wrap ? y_o + 1'b1 : y_o;
        end
    end

endmodule

// File: rtl/bp_cfg_loader.sv
// Boot sequencer: freezes and identifies every core tile over the config
// link, then unfreezes them all and raises done.
module bp_cfg_loader
    import bp_cfg_link_pkg::*;
#(
    parameter  int num_core_p       = 1,
    parameter  int cc_x_dim_p       = 1,
    parameter  int cfg_addr_width_p = 16,
    parameter  int cfg_data_width_p = 32,
    localparam int core_width_lp    = safe_clog2(num_core_p),
    localparam int x_width_lp       = safe_clog2(cc_x_dim_p),
    localparam int y_width_lp       = safe_clog2(num_core_p / cc_x_dim_p)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    bp_cfg_loader_if.master  cfg,
    output logic             done_o
);

    bp_cfg_loader_state_e     state_r;
    logic [core_width_lp-1:0] core_cnt;
    logic [x_width_lp-1:0]    x_cnt;
    logic [y_width_lp-1:0]    y_cnt;
    logic                     last_core;
    logic                     xfer;
    logic                     cnt_clear;
    logic                     cnt_incr;
    bp_cfg_cord_s             cord;

    assign xfer = cfg.cfg_v_o & cfg.cfg_ready_i;

    // Counters restart from core 0 for the unfreeze pass.
    assign cnt_clear = xfer & (state_r == e_cord) & last_core;
    assign cnt_incr  = xfer & ~last_core
                     & ((state_r == e_cord) | (state_r == e_unfreeze));

    bp_cfg_cord_counter #(
        .num_core_p (num_core_p),
        .cc_x_dim_p (cc_x_dim_p)
    ) cord_counter (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (cnt_clear),
        .incr_i  (cnt_incr),
        .core_o  (core_cnt),
        .x_o     (x_cnt),
        .y_o     (y_cnt),
        .last_o  (last_core)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= e_reset;
        end else begin
            unique case (state_r)
                e_reset:    state_r <= e_freeze;
                e_freeze:   if (xfer) state_r <= e_core_id;
                e_core_id:  if (xfer) state_r <= e_cord;
                e_cord:
                    if (xfer) state_r <= last_core ? e_unfreeze : e_freeze;
                e_unfreeze: if (xfer && last_core) state_r <= e_done;
                e_done:     state_r <= e_done;
                default:    state_r <= e_reset;
            endcase
        end
    end

    assign cord.x = 16'(x_cnt);
    assign cord.y = 16'(y_cnt);

    // Payload is a pure decode of registered state so it holds under stall.
    always_comb begin
        cfg.cfg_v_o    = 1'b0;
        cfg.cfg_core_o = '0;
        cfg.cfg_addr_o = '0;
        cfg.cfg_data_o = '0;
        unique case (state_r)
            e_freeze: begin
                cfg.cfg_v_o    = 1'b1;
                cfg.cfg_core_o = core_cnt;
                cfg.cfg_addr_o = cfg_addr_width_p'(e_cfg_freeze);
                cfg.cfg_data_o = cfg_data_width_p'(1'b1);
            end
            e_core_id: begin
                cfg.cfg_v_o    = 1'b1;
                cfg.cfg_core_o = core_cnt;
                cfg.cfg_addr_o = cfg_addr_width_p'(e_cfg_core_id);
                cfg.cfg_data_o = cfg_data_width_p'(core_cnt);
            end
            e_cord: begin
                cfg.cfg_v_o    = 1'b1;
                cfg.cfg_core_o = core_cnt;
                cfg.cfg_addr_o = cfg_addr_width_p'(e_cfg_cord);
                cfg.cfg_data_o = cfg_data_width_p'(cord);
            end
            e_unfreeze: begin
                cfg.cfg_v_o    = 1'b1;
                cfg.cfg_core_o = core_cnt;
                cfg.cfg_addr_o = cfg_addr_width_p'(e_cfg_freeze);
                cfg.cfg_data_o = '0;
            end
            default: begin
                cfg.cfg_v_o = 1'b0;
            end
        endcase
    end

    assign done_o = (state_r == e_done);

endmodule
